// File: rtl/sdram_port_sequencer.sv
// N-channel toggle-handshake request sequencer between core read strobes / ioctl download and SDRAM.
// Optional ack watchdog enabled by defining PORT_TIMEOUT_EN (adds timeout_err output).
module sdram_port_sequencer #(
  parameter int NCH     = 2,
  parameter int AW      = 22,
  parameter int CORE_AW = 16,
  parameter int IDX_W   = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  input  logic [NCH*IDX_W-1:0]   ch_index,
  input  logic [NCH-1:0]         core_stb,
  input  logic [NCH*CORE_AW-1:0] core_addr,
  output logic [NCH*16-1:0]      core_data,
  output logic [NCH-1:0]         core_valid,
  output logic [NCH*AW-1:0]      sd_addr,
  output logic [NCH*8-1:0]       sd_din,
  output logic [NCH-1:0]         sd_we,
  output logic [NCH-1:0]         sd_req,
  input  logic [NCH-1:0]         sd_ack,
  input  logic [NCH*16-1:0]      sd_dout,
`ifdef PORT_TIMEOUT_EN
  output logic [NCH-1:0]         timeout_err,
`endif
  output logic [NCH-1:0]         busy
);

  typedef enum logic [1:0] {ST_RESYNC, ST_IDLE, ST_PEND} state_t;

  logic           dl_q;
  logic           dl_rise;
  logic [NCH-1:0] wait_ch;
  logic           unused_bits;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) dl_q <= 1'b0;
    else       dl_q <= ioctl_download;
  end

  assign dl_rise     = ioctl_download & ~dl_q;
  assign ioctl_wait  = |wait_ch;
  assign unused_bits = &{1'b0, ioctl_index[7:IDX_W], ioctl_addr[24:AW], 1'(TIMEOUT)};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t         state_q, state_d;
    logic           req_q, req_d, we_q, we_d, valid_q, valid_d, busy_q;
    logic [AW-1:0]  addr_q, addr_d, qaddr_q, qaddr_d, rd_addr, ev_addr;
    logic [7:0]     din_q, din_d, qdin_q, qdin_d;
    logic [15:0]    data_q, data_d;
    logic           qv_q, qv_d, qwe_q, qwe_d;
    logic           rd_ev, wr_ev, ev, ack_match, qv_eff, q_locked, tmo_hit;

    always_comb begin
      rd_ev   = core_stb[c] & ~ioctl_download;
      wr_ev   = ioctl_download & ioctl_wr &
                (ioctl_index[IDX_W-1:0] == ch_index[c*IDX_W +: IDX_W]);
      ev      = rd_ev | wr_ev;
      rd_addr = '0;
      rd_addr[CORE_AW:0] = {core_addr[c*CORE_AW +: CORE_AW], 1'b0};
      ev_addr = wr_ev ? ioctl_addr[AW-1:0] : rd_addr;
    end

    // A download start cancels a queued read; queued writes survive.
    assign ack_match = (sd_ack[c] == req_q);
    assign qv_eff    = qv_q & ~(dl_rise & ~qwe_q);
    assign q_locked  = qv_eff & qwe_q;

`ifdef PORT_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          terr_q;

    assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
      cnt_d = cnt_q;
      if (req_d != req_q)          cnt_d = '0;
      else if (state_q == ST_PEND) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        cnt_q  <= '0;
        terr_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        if (state_q == ST_PEND && !ack_match && tmo_hit) terr_q <= 1'b1;
      end
    end

    assign timeout_err[c] = terr_q;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      din_d   = din_q;
      data_d  = data_q;
      valid_d = 1'b0;
      qv_d    = qv_eff;
      qwe_d   = qwe_q;
      qaddr_d = qaddr_q;
      qdin_d  = qdin_q;
      case (state_q)
        ST_RESYNC: if (ack_match) state_d = ST_IDLE;
        ST_IDLE: begin
          if (ev) begin
            req_d   = ~req_q;
            we_d    = wr_ev;
            addr_d  = ev_addr;
            if (wr_ev) din_d = ioctl_dout;
            state_d = ST_PEND;
          end
        end
        ST_PEND: begin
          if (ack_match) begin
            if (!we_q) begin
              data_d  = sd_dout[c*16 +: 16];
              valid_d = 1'b1;
            end
            // Queued request goes first; a coincident new event takes the freed slot.
            if (qv_eff) begin
              req_d  = ~req_q;
              we_d   = qwe_q;
              addr_d = qaddr_q;
              if (qwe_q) din_d = qdin_q;
              qv_d    = ev;
              qwe_d   = wr_ev;
              qaddr_d = ev_addr;
              qdin_d  = ioctl_dout;
            end else if (ev) begin
              req_d  = ~req_q;
              we_d   = wr_ev;
              addr_d = ev_addr;
              if (wr_ev) din_d = ioctl_dout;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (tmo_hit) begin
            if (!we_q) begin
              data_d  = 16'hFFFF;
              valid_d = 1'b1;
            end
            qv_d    = 1'b0;
            state_d = ST_RESYNC;
          end else if (ev && !q_locked) begin
            qv_d    = 1'b1;
            qwe_d   = wr_ev;
            qaddr_d = ev_addr;
            qdin_d  = ioctl_dout;
          end
        end
        default: state_d = ST_RESYNC;
      endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        state_q <= ST_RESYNC;
        req_q   <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= '0;
        din_q   <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        qv_q    <= 1'b0;
        qwe_q   <= 1'b0;
        qaddr_q <= '0;
        qdin_q  <= '0;
      end else begin
        state_q <= state_d;
        req_q   <= req_d;
        we_q    <= we_d;
        addr_q  <= addr_d;
        din_q   <= din_d;
        data_q  <= data_d;
        valid_q <= valid_d;
        busy_q  <= (state_d != ST_IDLE);
        qv_q    <= qv_d;
        qwe_q   <= qwe_d;
        qaddr_q <= qaddr_d;
        qdin_q  <= qdin_d;
      end
    end

    assign sd_req[c]            = req_q;
    assign sd_we[c]             = we_q;
    assign sd_addr[c*AW +: AW]  = addr_q;
    assign sd_din[c*8 +: 8]     = din_q;
    assign core_data[c*16 +: 16] = data_q;
    assign core_valid[c]        = valid_q;
    assign busy[c]              = busy_q;
    assign wait_ch[c]           = ((state_q == ST_PEND) && we_q) || (qv_q && qwe_q);
  end

endmodule

// File: tb/tb_sdram_port_sequencer.sv
// Self-checking bench for sdram_port_sequencer: vector table, hand sequences, read-data scoreboard.
module tb_sdram_port_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [11:0] ch_index;
  logic [1:0]  core_stb;
  logic [31:0] core_addr;
  logic [31:0] core_data;
  logic [1:0]  core_valid;
  logic [43:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_we;
  logic [1:0]  sd_req;
  logic [1:0]  sd_ack;
  logic [31:0] sd_dout;
  logic [1:0]  busy;
`ifdef PORT_TIMEOUT_EN
  logic [1:0]  timeout_err;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [1:0]  exp_req;
  logic [15:0] sb0[$];
  logic [15:0] sb1[$];

  sdram_port_sequencer #(
    .NCH(2), .AW(22), .CORE_AW(16), .IDX_W(6), .TIMEOUT(15)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .ch_index(ch_index), .core_stb(core_stb), .core_addr(core_addr),
    .core_data(core_data), .core_valid(core_valid),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_req(sd_req),
    .sd_ack(sd_ack), .sd_dout(sd_dout),
`ifdef PORT_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Read-data scoreboard: every core_valid pulse must match the oldest expected word.
  always @(posedge clk_sys) begin
    #1;
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        if (core_valid[c]) begin
          if ((c == 0 && sb0.size() == 0) || (c == 1 && sb1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL core_valid%0d: got unexpected pulse expected none", c);
          end else if (c == 0) begin
            check("core_data0", {16'h0, core_data[15:0]}, {16'h0, sb0.pop_front()});
          end else begin
            check("core_data1", {16'h0, core_data[31:16]}, {16'h0, sb1.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic push_exp(input int ch, input logic [15:0] d);
    if (ch == 0) sb0.push_back(d);
    else         sb1.push_back(d);
  endtask

  task automatic ack(input int ch, input logic [15:0] d);
    sd_dout[ch*16 +: 16] = d;
    sd_ack[ch] = exp_req[ch];
    tick();
  endtask

  task automatic strobe(input int ch, input logic [15:0] a);
    core_stb[ch] = 1'b1;
    core_addr[ch*16 +: 16] = a;
    tick();
    core_stb[ch] = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    bit          dl;
    int          ch;
    logic [15:0] caddr;
    logic [7:0]  idx;
    logic [24:0] iaddr;
    logic [7:0]  idata;
    logic [15:0] rdata;
    bit          hit;
    logic [21:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 0, 0, 16'h1234, 8'h00, 25'h0,       8'h00, 16'hBEEF, 1, 22'h002468};
    vecs[1] = '{0, 0, 1, 16'hFFFF, 8'h00, 25'h0,       8'h00, 16'h1357, 1, 22'h01FFFE};
    vecs[2] = '{0, 0, 0, 16'h0000, 8'h00, 25'h0,       8'h00, 16'hA5A5, 1, 22'h000000};
    vecs[3] = '{1, 1, 1, 16'h0000, 8'h01, 25'h10,      8'h5A, 16'h0000, 1, 22'h000010};
    vecs[4] = '{1, 1, 0, 16'h0000, 8'h00, 25'h1ABCDEF, 8'hC3, 16'h0000, 1, 22'h2BCDEF};
    vecs[5] = '{1, 1, 1, 16'h0000, 8'hC1, 25'h3F,      8'h99, 16'h0000, 1, 22'h00003F};
    vecs[6] = '{1, 1, 0, 16'h0000, 8'h02, 25'h44,      8'h77, 16'h0000, 0, 22'h000000};
    vecs[7] = '{0, 1, 0, 16'h4321, 8'h3F, 25'h0,       8'h00, 16'h0000, 0, 22'h000000};

    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ch_index = {6'd1, 6'd0};
    core_stb = '0; core_addr = '0; sd_ack = 2'b01; sd_dout = '0; exp_req = '0;
    repeat (3) tick();
    check("rst_sd_req", {30'h0, sd_req}, 32'h0);
    check("rst_busy", {30'h0, busy}, 32'h0);
    check("rst_core_valid", {30'h0, core_valid}, 32'h0);
    check("rst_sd_we", {30'h0, sd_we}, 32'h0);
    check("rst_ioctl_wait", {31'h0, ioctl_wait}, 32'h0);
    check("rst_sd_addr", sd_addr[31:0], 32'h0);

    // Released while ack still toggled: channel 0 must stay in resync and ignore strobes.
    reset = 1'b0;
    core_stb[0] = 1'b1; core_addr[15:0] = 16'h0077;
    tick();
    check("resync_busy", {30'h0, busy}, 32'h1);
    tick();
    check("resync_no_req", {30'h0, sd_req}, 32'h0);
    core_stb = '0;
    sd_ack[0] = 1'b0;
    tick();
    check("resync_exit_busy", {30'h0, busy}, 32'h0);
    check("resync_exit_req", {30'h0, sd_req}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      ioctl_download = vecs[i].dl;
      if (vecs[i].wr) begin
        ioctl_index = vecs[i].idx; ioctl_wr = 1'b1;
        ioctl_addr = vecs[i].iaddr; ioctl_dout = vecs[i].idata;
      end else begin
        ioctl_index = vecs[i].idx;
        core_stb[vecs[i].ch] = 1'b1;
        core_addr[vecs[i].ch*16 +: 16] = vecs[i].caddr;
      end
      tick();
      ioctl_wr = 1'b0; core_stb = '0;
      if (vecs[i].hit) exp_req[vecs[i].ch] = ~exp_req[vecs[i].ch];
      check($sformatf("v%0d_sd_req", i), {30'h0, sd_req}, {30'h0, exp_req});
      if (vecs[i].hit) begin
        check($sformatf("v%0d_sd_addr", i), {10'h0, sd_addr[vecs[i].ch*22 +: 22]}, {10'h0, vecs[i].exp_addr});
        check($sformatf("v%0d_sd_we", i), {31'h0, sd_we[vecs[i].ch]}, {31'h0, vecs[i].wr});
        if (vecs[i].wr)
          check($sformatf("v%0d_sd_din", i), {24'h0, sd_din[vecs[i].ch*8 +: 8]}, {24'h0, vecs[i].idata});
        else
          push_exp(vecs[i].ch, vecs[i].rdata);
        repeat (2) tick();
        check($sformatf("v%0d_wait_pend", i), {31'h0, ioctl_wait}, {31'h0, vecs[i].wr});
        check($sformatf("v%0d_busy_pend", i), {31'h0, busy[vecs[i].ch]}, 32'h1);
        ack(vecs[i].ch, vecs[i].rdata);
        check($sformatf("v%0d_wait_done", i), {31'h0, ioctl_wait}, 32'h0);
        check($sformatf("v%0d_busy_done", i), {30'h0, busy}, 32'h0);
        tick();
      end else begin
        check($sformatf("v%0d_busy_idle", i), {30'h0, busy}, 32'h0);
      end
      ioctl_download = 1'b0;
      tick();
    end

    // Overlap: three strobes while addr 0 pends; only the last one follows, back-to-back.
    strobe(0, 16'h0000);
    exp_req[0] = ~exp_req[0];
    push_exp(0, 16'h1111);
    strobe(0, 16'h0001);
    strobe(0, 16'h0002);
    strobe(0, 16'h0003);
    check("ovl_held_addr", {10'h0, sd_addr[21:0]}, 32'h0);
    check("ovl_held_req", {30'h0, sd_req}, {30'h0, exp_req});
    ack(0, 16'h1111);
    exp_req[0] = ~exp_req[0];
    push_exp(0, 16'h3333);
    check("ovl_b2b_req", {30'h0, sd_req}, {30'h0, exp_req});
    check("ovl_b2b_addr", {10'h0, sd_addr[21:0]}, 32'h6);
    tick();
    check("ovl_busy", {30'h0, busy}, 32'h1);
    ack(0, 16'h3333);
    tick();
    check("ovl_no_stale_req", {30'h0, sd_req}, {30'h0, exp_req});
    check("ovl_idle", {30'h0, busy}, 32'h0);

    // Ack match coinciding with a new strobe issues the strobe directly.
    strobe(0, 16'h0010);
    exp_req[0] = ~exp_req[0];
    push_exp(0, 16'h2222);
    core_stb[0] = 1'b1; core_addr[15:0] = 16'h0020;
    ack(0, 16'h2222);
    core_stb = '0;
    exp_req[0] = ~exp_req[0];
    push_exp(0, 16'h4444);
    check("coin_req", {30'h0, sd_req}, {30'h0, exp_req});
    check("coin_addr", {10'h0, sd_addr[21:0]}, 32'h40);
    ack(0, 16'h4444);
    check("coin_idle", {30'h0, busy}, 32'h0);
    tick();

    // Download start discards a queued read; the in-flight read still completes.
    strobe(0, 16'h0050);
    exp_req[0] = ~exp_req[0];
    push_exp(0, 16'h5555);
    strobe(0, 16'h0060);
    ioctl_index = 8'h3F; ioctl_download = 1'b1;
    tick();
    ack(0, 16'h5555);
    tick();
    check("dlr_no_reissue", {30'h0, sd_req}, {30'h0, exp_req});
    check("dlr_idle", {30'h0, busy}, 32'h0);
    ioctl_download = 1'b0;
    tick();

    // Back-to-back download writes on channel 1: second one is queued and throttled.
    ioctl_download = 1'b1; ioctl_index = 8'h01; ioctl_wr = 1'b1;
    ioctl_addr = 25'h20; ioctl_dout = 8'h11;
    tick();
    exp_req[1] = ~exp_req[1];
    ioctl_addr = 25'h21; ioctl_dout = 8'h22;
    tick();
    ioctl_wr = 1'b0;
    check("qw_wait", {31'h0, ioctl_wait}, 32'h1);
    check("qw_first_addr", {10'h0, sd_addr[43:22]}, 32'h20);
    ack(1, 16'h0);
    exp_req[1] = ~exp_req[1];
    check("qw_req", {30'h0, sd_req}, {30'h0, exp_req});
    check("qw_addr", {10'h0, sd_addr[43:22]}, 32'h21);
    check("qw_din", {24'h0, sd_din[15:8]}, 32'h22);
    check("qw_wait_still", {31'h0, ioctl_wait}, 32'h1);
    ack(1, 16'h0);
    check("qw_wait_drop", {31'h0, ioctl_wait}, 32'h0);
    check("qw_idle", {30'h0, busy}, 32'h0);
    ioctl_download = 1'b0;
    tick();

`ifdef PORT_TIMEOUT_EN
    strobe(0, 16'h0099);
    exp_req[0] = ~exp_req[0];
    repeat (14) tick();
    check("tmo_before", {30'h0, timeout_err}, 32'h0);
    push_exp(0, 16'hFFFF);
    tick();
    check("tmo_err", {30'h0, timeout_err}, 32'h1);
    check("tmo_resync_busy", {30'h0, busy}, 32'h1);
    ack(0, 16'h0);
    check("tmo_recover", {30'h0, busy}, 32'h0);
    check("tmo_sticky", {30'h0, timeout_err}, 32'h1);
    tick();
`endif

    repeat (2) tick();
    check("sb0_empty", sb0.size(), 32'h0);
    check("sb1_empty", sb1.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
